// File: rtl/gba_rom_loader.sv
// gba_rom_loader: boot-time copy of the cart ROM image from SPI flash (mode 0) into BRAM.
// Sends release-power-down, waits, then issues one continuous 0x03 read streaming WORDS words.
module gba_rom_loader #(
    parameter int          WORDS        = 512,
    parameter int          AW           = 9,
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter int          CLK_DIV      = 2,
    parameter int          WAKE_WAIT    = 256
) (
    input  logic          clk,
    input  logic          rst,
    output logic          spi_cs_n,
    output logic          spi_sck,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int WW = WAKE_WAIT > 1 ? $clog2(WAKE_WAIT) : 1;

    typedef enum logic [2:0] {WAKE_CMD, WAKE_WAIT_S, RD_CMD, RD_DATA, WRITE, FINISH, DONE} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div, div_nx;
    logic [6:0]    cnt, cnt_nx, last;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic [31:0]   sr, sr_nx;
    logic [15:0]   rx, rx_nx, wr_data_nx;
    logic [AW-1:0] idx, idx_nx, wr_addr_nx;
    logic          cs_nx, sck_nx, mosi_nx, tick;

    assign tick  = div == DW'(CLK_DIV - 1);
    assign last  = state == WAKE_CMD ? 7'd16 : 7'd64;
    assign wr_en = state == WRITE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAKE_CMD;
            div      <= '0;
            cnt      <= '0;
            wcnt     <= '0;
            sr       <= {8'hAB, 24'h0};
            rx       <= '0;
            idx      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            div      <= div_nx;
            cnt      <= cnt_nx;
            wcnt     <= wcnt_nx;
            sr       <= sr_nx;
            rx       <= rx_nx;
            idx      <= idx_nx;
            wr_addr  <= wr_addr_nx;
            wr_data  <= wr_data_nx;
            spi_cs_n <= cs_nx;
            spi_sck  <= sck_nx;
            spi_mosi <= mosi_nx;
            busy     <= state_nx != DONE;
            done     <= state_nx == DONE;
        end
    end

    always_comb begin
        state_nx   = state;
        div_nx     = tick ? '0 : div + 1'b1;
        cnt_nx     = cnt;
        wcnt_nx    = wcnt;
        sr_nx      = sr;
        rx_nx      = rx;
        idx_nx     = idx;
        wr_addr_nx = wr_addr;
        wr_data_nx = wr_data;
        cs_nx      = spi_cs_n;
        sck_nx     = spi_sck;
        mosi_nx    = spi_mosi;
        case (state)
            // cnt counts half-periods: 0 = CS setup, odd = rise, even = fall, last+1 = CS hold
            WAKE_CMD, RD_CMD: if (tick) begin
                if (cnt == 7'd0) begin
                    cs_nx   = 1'b0;
                    mosi_nx = sr[31];
                    cnt_nx  = 7'd1;
                end else if (cnt == last + 7'd1) begin
                    cs_nx    = 1'b1;
                    mosi_nx  = 1'b0;
                    cnt_nx   = '0;
                    wcnt_nx  = '0;
                    state_nx = WAKE_WAIT_S;
                end else if (cnt[0]) begin
                    sck_nx = 1'b1;
                    cnt_nx = cnt + 7'd1;
                end else begin
                    sck_nx  = 1'b0;
                    sr_nx   = sr << 1;
                    mosi_nx = sr[30];
                    cnt_nx  = cnt + 7'd1;
                    if (state == RD_CMD && cnt == last) begin
                        mosi_nx  = 1'b0;
                        cnt_nx   = '0;
                        state_nx = RD_DATA;
                    end
                end
            end
            WAKE_WAIT_S: begin
                wcnt_nx = wcnt + 1'b1;
                if (wcnt == WW'(WAKE_WAIT - 1)) begin
                    wcnt_nx  = '0;
                    sr_nx    = {8'h03, FLASH_OFFSET};
                    state_nx = RD_CMD;
                end
            end
            RD_DATA: if (tick) begin
                cnt_nx = cnt + 7'd1;
                if (!cnt[0]) begin
                    sck_nx = 1'b1;
                    rx_nx  = {rx[14:0], spi_miso};
                end else begin
                    sck_nx = 1'b0;
                    if (cnt == 7'd31) begin
                        cnt_nx     = '0;
                        wr_addr_nx = idx;
                        wr_data_nx = {rx[7:0], rx[15:8]};
                        state_nx   = WRITE;
                    end
                end
            end
            WRITE: begin
                state_nx = idx == AW'(WORDS - 1) ? FINISH : RD_DATA;
                idx_nx   = idx == AW'(WORDS - 1) ? idx : idx + 1'b1;
            end
            // waiting for a tick keeps CS low for a full half-period after the last SCK fall
            FINISH: if (tick) begin
                cs_nx    = 1'b1;
                state_nx = DONE;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_gba_rom_loader.sv
// tb_gba_rom_loader: flash model plus scoreboard of expected BRAM writes for gba_rom_loader.
module tb_gba_rom_loader;
    localparam int WORDS = 8, AW = 3, CLK_DIV = 2, WAKE_WAIT = 20;

    logic          clk = 0, rst = 1;
    logic          spi_cs_n, spi_sck, spi_mosi, spi_miso, wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    gba_rom_loader #(.WORDS(WORDS), .AW(AW), .FLASH_OFFSET(24'h100000), .CLK_DIV(CLK_DIV),
                     .WAKE_WAIT(WAKE_WAIT)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0]  mem [16] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE,
                              8'h11, 8'h22, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'h5A};
    logic [15:0] exp_words [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                   16'h2211, 16'hFFFF, 16'h0000, 16'h5AA5};

    int          cyc = 0, nbits = 0, k = 0, cs_fall = 0;
    logic [31:0] cmd = 0;
    logic [23:0] a;
    logic        flash_miso = 0, rnd_mode = 0, rnd_bit = 0;
    int          txn_bits[$], txn_s[$], txn_e[$];
    logic [31:0] txn_cmd[$];

    assign spi_miso = rnd_mode ? rnd_bit : flash_miso;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge spi_cs_n) begin
        nbits   = 0;
        cmd     = 0;
        cs_fall = cyc;
    end

    always @(posedge spi_cs_n) if (nbits > 0) begin
        txn_bits.push_back(nbits);
        txn_cmd.push_back(cmd);
        txn_s.push_back(cs_fall);
        txn_e.push_back(cyc);
    end

    always @(posedge spi_sck) if (!spi_cs_n) begin
        if (nbits < 32) cmd = {cmd[30:0], spi_mosi};
        nbits++;
    end

    always @(negedge spi_sck) if (!spi_cs_n && nbits >= 32) begin
        k = nbits - 32;
        a = cmd[23:0] - 24'h100000;
        flash_miso = mem[4'(a + 24'(k / 8))][3'(7 - k % 8)];
    end

    logic [31:0] exp_addr[$], exp_data[$];
    int          wcount = 0, hi_len = 0;
    logic        prev_we = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            wcount++;
            chk("wr_en_pulse", prev_we, 0);
            if (exp_addr.size() == 0) chk("unexpected_write", wr_en, 0);
            else begin
                chk("wr_addr", wr_addr, exp_addr.pop_front());
                chk("wr_data", wr_data, exp_data.pop_front());
            end
        end
        prev_we = wr_en;
    end

    always @(negedge clk) begin
        if (rst) hi_len = 0;
        else if (spi_sck) hi_len++;
        else begin
            if (hi_len > 0) chk("sck_high_clks", hi_len, CLK_DIV);
            hi_len = 0;
        end
    end

    task automatic push_all();
        for (int i = 0; i < WORDS; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(exp_words[i]);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        int lowc, notdone, w0, n;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        push_all();
        rst = 0;
        @(negedge clk);
        chk("busy_after_release", busy, 1);
        wait_done("done_load1");
        chk("queue_empty1", exp_addr.size(), 0);
        chk("writes1", wcount, WORDS);
        chk("cs_idle1", spi_cs_n, 1);
        chk("busy_end1", busy, 0);
        chk("txns1", txn_bits.size(), 2);
        chk("wake_bits", txn_bits[0], 8);
        chk("wake_cmd", txn_cmd[0], 32'hAB);
        chk("rd_cmd", txn_cmd[1], 32'h03100000);
        chk("rd_bits", txn_bits[1], 32 + 16 * WORDS);
        chk("wake_idle", (txn_s[1] - txn_e[0]) >= WAKE_WAIT, 1);

        rnd_mode = 1;
        lowc = 0;
        notdone = 0;
        w0 = wcount;
        repeat (2000) begin
            @(negedge clk);
            rnd_bit = 1'($urandom_range(1));
            if (!spi_cs_n) lowc++;
            if (!done || busy) notdone++;
        end
        rnd_mode = 0;
        chk("post_done_cs_low", lowc, 0);
        chk("post_done_state", notdone, 0);
        chk("post_done_writes", wcount, w0);

        txn_bits.delete(); txn_cmd.delete(); txn_s.delete(); txn_e.delete();
        rst = 1;
        #1 chk("rst_clears_done", done, 0);
        repeat (2) @(negedge clk);
        push_all();
        rst = 0;
        w0 = wcount;
        n = 0;
        while (wcount < w0 + 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_word3", wcount - w0, 3);
        repeat (10) @(posedge clk);
        #1 rst = 1;
        #1 chk("midrst_cs_n", spi_cs_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sck", spi_sck, 0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge clk);
        push_all();
        rst = 0;
        wait_done("done_load2");
        chk("queue_empty2", exp_addr.size(), 0);
        chk("writes2", wcount - w0, 3 + WORDS);
        chk("txns2", txn_bits.size(), 4);
        chk("rewake_cmd", txn_cmd[2], 32'hAB);
        chk("rewake_bits", txn_bits[2], 8);
        chk("reread_cmd", txn_cmd[3], 32'h03100000);
        chk("reread_bits", txn_bits[3], 32 + 16 * WORDS);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
